// File: rtl/pomdp_step3_action_select_if.sv
// rtl/pomdp_step3_action_select_if.sv - step 3 bundle: start/status handshake plus candidate, belief and result buses
// Ports (signals carried by the interface):
//   en                   start pulse from step 2
//   gamma_action_belief  [N_ACTION][N_BELIEF][N_STATE] x W candidate alphas
//   point_belief         [N_BELIEF][N_STATE] x W belief points
//   busy, done, out_valid status
//   alpha_out            [N_BELIEF][N_STATE] x W selected alpha per belief
//   policy_action        [N_BELIEF] x AW arg-max action per belief
//   best_value           [N_BELIEF] x DW winning dot product per belief
// Modports: master = upstream/consumer side, slave = the stage itself.
interface pomdp_step3_action_select_if #(
  parameter int N_ACTION = 3,
  parameter int N_BELIEF = 16,
  parameter int N_STATE  = 2,
  parameter int W        = 16,
  parameter int DW       = 2*W + $clog2(N_STATE),
  parameter int AW       = (N_ACTION > 1) ? $clog2(N_ACTION) : 1
);
  logic                                                   en;
  logic [N_ACTION-1:0][N_BELIEF-1:0][N_STATE-1:0][W-1:0] gamma_action_belief;
  logic [N_BELIEF-1:0][N_STATE-1:0][W-1:0]               point_belief;
  logic                                                   busy;
  logic                                                   done;
  logic                                                   out_valid;
  logic [N_BELIEF-1:0][N_STATE-1:0][W-1:0]               alpha_out;
  logic [N_BELIEF-1:0][AW-1:0]                            policy_action;
  logic [N_BELIEF-1:0][DW-1:0]                            best_value;

  modport master (
    output en, gamma_action_belief, point_belief,
    input  busy, done, out_valid, alpha_out, policy_action, best_value
  );

  modport slave (
    input  en, gamma_action_belief, point_belief,
    output busy, done, out_valid, alpha_out, policy_action, best_value
  );
endinterface

// File: rtl/pomdp_step3_action_select.sv
// rtl/pomdp_step3_action_select.sv - PBVI backup stage 3: per-belief arg-max action selection
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    pomdp_step3_action_select_if.slave (en, gamma_action_belief, point_belief in;
//          busy, done, out_valid, alpha_out, policy_action, best_value out)
// One (belief, action) pair is evaluated per cycle; the winner of each belief is
// committed on its last action, so a run takes N_BELIEF*N_ACTION EVAL cycles.
module pomdp_step3_action_select #(
  parameter int N_ACTION = 3,
  parameter int N_BELIEF = 16,
  parameter int N_STATE  = 2,
  parameter int W        = 16,
  parameter int DW       = 2*W + $clog2(N_STATE),
  parameter int AW       = (N_ACTION > 1) ? $clog2(N_ACTION) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  pomdp_step3_action_select_if.slave    bus
);
  localparam int BW = (N_BELIEF > 1) ? $clog2(N_BELIEF) : 1;

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  state_t state_q, state_d;

  logic [N_ACTION-1:0][N_BELIEF-1:0][N_STATE-1:0][W-1:0] snap_gamma;
  logic [N_BELIEF-1:0][N_STATE-1:0][W-1:0]               snap_belief;
  logic [AW-1:0]                                          a_q;
  logic [BW-1:0]                                          b_q;
  logic [DW-1:0]                                          best_val_q;
  logic [AW-1:0]                                          best_act_q;

  logic [N_BELIEF-1:0][N_STATE-1:0][W-1:0]               alpha_q;
  logic [N_BELIEF-1:0][AW-1:0]                            policy_q;
  logic [N_BELIEF-1:0][DW-1:0]                            value_q;
  logic                                                   out_valid_q;

  logic          start;
  logic          last_action;
  logic          last_belief;
  logic [DW-1:0] dot;
  logic          take;
  logic [DW-1:0] win_val;
  logic [AW-1:0] win_act;

  assign bus.busy          = (state_q == EVAL);
  assign bus.done          = (state_q == DONE);
  assign bus.out_valid     = out_valid_q;
  assign bus.alpha_out     = alpha_q;
  assign bus.policy_action = policy_q;
  assign bus.best_value    = value_q;

  assign start       = (state_q == IDLE) && bus.en;
  assign last_action = (a_q == AW'(N_ACTION - 1));
  assign last_belief = (b_q == BW'(N_BELIEF - 1));

  // Dot product of the current candidate against the current belief. Each
  // product fits in 2W bits and the sum of N_STATE of them in DW bits.
  always_comb begin
    dot = '0;
    for (int s = 0; s < N_STATE; s++) begin
      dot = dot + DW'(snap_gamma[a_q][b_q][s]) * DW'(snap_belief[b_q][s]);
    end
  end

  // Action 0 seeds the running best; later actions must be strictly better,
  // so ties resolve to the lowest action index.
  assign take    = (a_q == '0) || (dot > best_val_q);
  assign win_val = take ? dot : best_val_q;
  assign win_act = take ? a_q : best_act_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.en) state_d = EVAL;
      EVAL: if (last_action && last_belief) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_gamma  <= '0;
      snap_belief <= '0;
      a_q         <= '0;
      b_q         <= '0;
      best_val_q  <= '0;
      best_act_q  <= '0;
      alpha_q     <= '0;
      policy_q    <= '0;
      value_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (start) begin
        // Inputs are captured once here and never read again during the run.
        snap_gamma  <= bus.gamma_action_belief;
        snap_belief <= bus.point_belief;
        a_q         <= '0;
        b_q         <= '0;
        best_val_q  <= '0;
        best_act_q  <= '0;
        out_valid_q <= 1'b0;
      end else if (state_q == EVAL) begin
        best_val_q <= win_val;
        best_act_q <= win_act;
        if (last_action) begin
          alpha_q[b_q]  <= snap_gamma[win_act][b_q];
          policy_q[b_q] <= win_act;
          value_q[b_q]  <= win_val;
          a_q           <= '0;
          b_q           <= b_q + BW'(1);
          if (last_belief) begin
            out_valid_q <= 1'b1;
          end
        end else begin
          a_q <= a_q + AW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_pomdp_step3_action_select.sv
// tb/tb_pomdp_step3_action_select.sv - scoreboard bench for pomdp_step3_action_select
module tb_pomdp_step3_action_select;
  localparam int NA  = 3;
  localparam int NB  = 16;
  localparam int NS  = 2;
  localparam int W   = 16;
  localparam int DW  = 2*W + $clog2(NS);
  localparam int AW  = $clog2(NA);
  localparam int LAT = NA*NB;  // posedges from the en-sampling edge to the edge that raises done

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pomdp_step3_action_select_if #(.N_ACTION(NA), .N_BELIEF(NB), .N_STATE(NS), .W(W)) bus();

  pomdp_step3_action_select #(.N_ACTION(NA), .N_BELIEF(NB), .N_STATE(NS), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0]  alpha [NB][NS];
    logic [AW-1:0] act [NB];
    logic [DW-1:0] val [NB];
    int            start;
  } exp_t;

  exp_t sb[$];
  exp_t last_e;

  logic [W-1:0] g [NA][NB][NS];
  logic [W-1:0] p [NB][NS];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference: for each belief, the action with the largest belief-weighted
  // value; the first action reaching the maximum wins.
  function automatic exp_t model();
    exp_t e;
    for (int b = 0; b < NB; b++) begin
      logic [63:0] best;
      int          ba;
      best = 0;
      ba   = 0;
      for (int a = 0; a < NA; a++) begin
        logic [63:0] v;
        v = 0;
        for (int s = 0; s < NS; s++) v = v + 64'(g[a][b][s]) * 64'(p[b][s]);
        if (a == 0 || v > best) begin
          best = v;
          ba   = a;
        end
      end
      e.act[b] = AW'(ba);
      e.val[b] = DW'(best);
      for (int s = 0; s < NS; s++) e.alpha[b][s] = g[ba][b][s];
    end
    e.start = 0;
    return e;
  endfunction

  task automatic drive_inputs();
    for (int a = 0; a < NA; a++)
      for (int b = 0; b < NB; b++)
        for (int s = 0; s < NS; s++) bus.gamma_action_belief[a][b][s] = g[a][b][s];
    for (int b = 0; b < NB; b++)
      for (int s = 0; s < NS; s++) bus.point_belief[b][s] = p[b][s];
  endtask

  task automatic randomize_inputs(input int maxv);
    for (int a = 0; a < NA; a++)
      for (int b = 0; b < NB; b++)
        for (int s = 0; s < NS; s++) g[a][b][s] = W'($urandom_range(maxv, 0));
    for (int b = 0; b < NB; b++)
      for (int s = 0; s < NS; s++) p[b][s] = W'($urandom_range(maxv, 0));
  endtask

  // Presents en for one edge; when now=1 en is raised in the current cycle.
  task automatic start_run(input bit now);
    exp_t e;
    drive_inputs();
    e = model();
    if (!now) @(negedge clk);
    bus.en = 1'b1;
    @(posedge clk);
    #1;
    e.start = cyc;
    last_e = e;
    sb.push_back(e);
    @(negedge clk);
    bus.en = 1'b0;
  endtask

  // Returns at the negedge following the done cycle.
  task automatic wait_done();
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", bus.done, 1);
    @(negedge clk);
    chk("done_pulse_width", bus.done, 0);
    chk("out_valid_hold", bus.out_valid, 1);
    chk("sb_drained", sb.size(), 0);
  endtask

  // Monitor: pops the oldest expectation whenever the stage signals done.
  always @(negedge clk) begin
    if (rst_n && bus.done === 1'b1) begin
      chk("sb_nonempty", 64'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("latency", cyc - e.start, LAT);
        chk("out_valid_at_done", bus.out_valid, 1);
        chk("busy_at_done", bus.busy, 0);
        for (int b = 0; b < NB; b++) begin
          chk($sformatf("policy[%0d]", b), bus.policy_action[b], e.act[b]);
          chk($sformatf("value[%0d]", b), bus.best_value[b], e.val[b]);
          for (int s = 0; s < NS; s++)
            chk($sformatf("alpha[%0d][%0d]", b, s), bus.alpha_out[b][s], e.alpha[b][s]);
        end
      end
    end
  end

  initial begin
    bus.en = 1'b0;
    bus.gamma_action_belief = '0;
    bus.point_belief = '0;
    #12;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_outputs_zero", 64'(bus.alpha_out == '0 && bus.policy_action == '0 && bus.best_value == '0), 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Dominant action 1.
    for (int a = 0; a < NA; a++)
      for (int b = 0; b < NB; b++)
        for (int s = 0; s < NS; s++) g[a][b][s] = (a == 1) ? W'(500) : W'(1);
    for (int b = 0; b < NB; b++)
      for (int s = 0; s < NS; s++) p[b][s] = W'(1);
    start_run(0);
    @(negedge clk);
    chk("busy_in_eval", bus.busy, 1);
    wait_done();
    chk("dominant_policy_15", bus.policy_action[15], 1);
    chk("dominant_value_7", bus.best_value[7], 1000);

    // Belief-dependent choice with a tie on belief 2.
    for (int b = 0; b < NB; b++) begin
      g[0][b][0] = 100; g[0][b][1] = 0;
      g[1][b][0] = 0;   g[1][b][1] = 0;
      g[2][b][0] = 0;   g[2][b][1] = 100;
      p[b][0] = W'($urandom_range(9, 0));
      p[b][1] = W'($urandom_range(9, 0));
    end
    p[0][0] = 3; p[0][1] = 1;
    p[1][0] = 1; p[1][1] = 3;
    p[2][0] = 2; p[2][1] = 2;
    start_run(0);
    wait_done();
    chk("bdep_act_0", bus.policy_action[0], 0);
    chk("bdep_val_0", bus.best_value[0], 300);
    chk("bdep_act_1", bus.policy_action[1], 2);
    chk("bdep_val_1", bus.best_value[1], 300);
    chk("bdep_act_2_tie", bus.policy_action[2], 0);
    chk("bdep_val_2", bus.best_value[2], 200);

    // All actions identical: ties everywhere.
    randomize_inputs(65535);
    for (int a = 1; a < NA; a++)
      for (int b = 0; b < NB; b++)
        for (int s = 0; s < NS; s++) g[a][b][s] = g[0][b][s];
    start_run(0);
    wait_done();
    chk("tie_all_zero", 64'(bus.policy_action == '0), 1);

    // Width extremes.
    for (int a = 0; a < NA; a++)
      for (int b = 0; b < NB; b++)
        for (int s = 0; s < NS; s++) g[a][b][s] = '1;
    for (int b = 0; b < NB; b++)
      for (int s = 0; s < NS; s++) p[b][s] = '1;
    start_run(0);
    wait_done();
    chk("extreme_value_0", bus.best_value[0], 64'h1_FFFC_0002);
    chk("extreme_value_15", bus.best_value[15], 64'h1_FFFC_0002);

    // Randomized runs, some with narrow ranges to force frequent ties.
    for (int r = 0; r < 6; r++) begin
      randomize_inputs((r % 2 == 0) ? 65535 : 3);
      start_run(0);
      wait_done();
    end

    // Protocol: en re-pulsed mid-run and inputs changed after the start edge.
    randomize_inputs(65535);
    start_run(0);
    while (cyc < last_e.start + 5) @(negedge clk);
    bus.en = 1'b1;
    for (int a = 0; a < NA; a++)
      for (int b = 0; b < NB; b++)
        for (int s = 0; s < NS; s++) bus.gamma_action_belief[a][b][s] = W'($urandom);
    for (int b = 0; b < NB; b++)
      for (int s = 0; s < NS; s++) bus.point_belief[b][s] = W'($urandom);
    @(negedge clk);
    bus.en = 1'b0;
    chk("busy_after_repulse", bus.busy, 1);
    while (cyc < last_e.start + 30) @(negedge clk);
    bus.en = 1'b1;
    chk("committed_policy_0_stable", bus.policy_action[0], last_e.act[0]);
    chk("committed_value_0_stable", bus.best_value[0], last_e.val[0]);
    @(negedge clk);
    bus.en = 1'b0;
    wait_done();
    randomize_inputs(65535);
    start_run(1);
    chk("out_valid_drop_on_restart", bus.out_valid, 0);
    chk("busy_on_restart", bus.busy, 1);
    wait_done();

    // Asynchronous reset mid-run discards everything.
    randomize_inputs(65535);
    start_run(0);
    repeat (20) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_done", bus.done, 0);
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_outputs_zero", 64'(bus.alpha_out == '0 && bus.policy_action == '0 && bus.best_value == '0), 1);
    @(negedge clk);
    rst_n = 1'b1;
    randomize_inputs(65535);
    start_run(0);
    wait_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pomdp_step3_action_select.md
Name: pomdp_step3_action_select

Overview:
- Stage 3 of the PBVI backup pipeline, directly downstream of step 2.
- Consumes the per-action candidate alpha vectors from step 2, `gamma_action_belief[action][belief][state]`, and the belief-point set.
- For every belief point it serially evaluates each action's candidate against that belief and keeps the arg-max action.
- Emits the new alpha-vector set (one vector per belief) plus the greedy policy action per belief, with a one-cycle done pulse.

Parameters:
- N_ACTION, 3, number of actions.
- N_BELIEF, 16, number of belief points.
- N_STATE, 2, number of hidden states.
- W, 16, unsigned width of alpha and belief entries.
- DW, 2*W+$clog2(N_STATE), dot-product accumulator width (33 at defaults).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  start pulse from step 2 (its en_step3)
- gamma_action_belief  in  [W-1:0] x [N_ACTION][N_BELIEF][N_STATE]  candidate alphas from step 2
- point_belief  in  [W-1:0] x [N_BELIEF][N_STATE]  belief points
- busy  out  1  high while evaluating
- done  out  1  one-cycle pulse when all outputs are committed
- out_valid  out  1  high from done until the next accepted en
- alpha_out  out  [W-1:0] x [N_BELIEF][N_STATE]  selected alpha vector per belief
- policy_action  out  [$clog2(N_ACTION)-1:0] x [N_BELIEF]  arg-max action per belief
- best_value  out  [DW-1:0] x [N_BELIEF]  winning dot product per belief

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk.
  - busy, done and out_valid reset to 0.
  - alpha_out, policy_action and best_value reset to all 0.
  - FSM resets to IDLE; belief counter b and action counter a reset to 0.
- FSM states: IDLE, EVAL, DONE.
  - IDLE: en=1 at a clock edge snapshots gamma_action_belief and point_belief into internal registers, clears b, a, best_val and best_act, clears out_valid, and moves to EVAL.
    - Inputs are never read after the snapshot; upstream may change them freely.
  - EVAL: one action per cycle. dot = sum over s of snap_gamma[a][b][s]*snap_belief[b][s], unsigned, DW bits, no truncation.
    - a==0: the candidate unconditionally becomes the best.
    - a>0: the candidate replaces the best only if dot > best_val (strict). Ties keep the lower action index.
    - a==N_ACTION-1: commit the final winner for belief b, i.e. alpha_out[b] = snap_gamma[winner][b][*], policy_action[b] = winner, best_value[b] = winner dot. Then a=0, b=b+1.
    - Belief b==N_BELIEF-1 at its last action: go to DONE.
  - DONE: done=1 and out_valid=1 for exactly one cycle, then IDLE. An en in DONE is not accepted; it must be re-presented in IDLE.
- busy=1 exactly in EVAL.
- Latency: with en sampled at edge 0, EVAL occupies N_BELIEF*N_ACTION cycles (48), and done is high in the cycle after edge 48.
  - From en sampled to done observed is N_BELIEF*N_ACTION+1 = 49 edges.
  - Next en is accepted at edge 50 at the earliest.
- Committed per-belief outputs update only at their commit cycle and otherwise hold. Outputs of belief b are stable once committed, even while later beliefs are still evaluating.
- en while busy: ignored; no restart and no snapshot change.
- Reset mid-operation: immediate return to IDLE with all outputs zero; partial results are discarded.
- Arithmetic: all operands unsigned. The accumulator cannot overflow at DW bits (max 2*(2^W-1)^2 < 2^DW).

Test Plan:
- Reset: assert rst_n=0 mid-run -> busy=done=out_valid=0 and all alpha_out/policy_action/best_value = 0 asynchronously. en is accepted normally after release.
- Dominant action: gamma[1][*][*]=(500,500), others (1,1), beliefs (1,1) -> policy_action=1 for all 16 beliefs, alpha_out[b]=(500,500), best_value=1000, done exactly 49 cycles after en.
- Belief-dependent choice: gamma[0]=(100,0), gamma[1]=(0,0), gamma[2]=(0,100) for all b; belief0=(3,1), belief1=(1,3), belief2=(2,2):
  - belief0 -> action 0, value 300.
  - belief1 -> action 2, value 300.
  - belief2 -> action 0 (tie), value 200.
- Ties: all actions identical -> policy_action=0 everywhere.
- Width extremes: every input 0xFFFF -> best_value = 0x1FFFC0002 for every belief, no wrap.
- Protocol: re-pulse en at cycles 5 and 30 of a run, and change inputs after the start edge -> no restart, results reflect the snapshot, done at cycle 49. A second en at cycle 50 starts a new run with out_valid dropping.
